ex_mem_skid: RTL and testbench
==============================

Name: ex_mem_skid

Overview:
- Next-generation EX/MEM pipeline register that replaces the free-running register with a valid/ready elastic stage.
- Carries the EX-stage control and data bundle into MEM, holding it intact while MEM stalls (for example on multi-cycle data memory).
- A 2-entry arrangement (main + skid) keeps in_ready registered and avoids a combinational ready path back into EX.
- Adds pipeline flush, optional x0 write squashing, occupancy reporting and a saturating stall counter.

Parameters:
- PC_WIDTH, 16, width of the PC field.
- DATA_WIDTH, 16, width of the ALU result, store data and JAL link value.
- REGADDR_WIDTH, 4, width of the destination register address.
- ZERO_REG_SQUASH, 1, when 1 a captured reg_write is forced to 0 if rd==0.
- STALL_CNT_WIDTH, 16, width of the stall cycle counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- flush  in  1  discard all held entries (branch/jump redirect)
- in_valid  in  1  EX presents a valid bundle
- in_ready  out  1  stage can accept a bundle this cycle
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_is_jal  in  1 each  EX control bits
- ex_pc  in  PC_WIDTH  instruction PC
- ex_alu_result  in  DATA_WIDTH  ALU result / address
- ex_reg_data2  in  DATA_WIDTH  store data
- ex_rd  in  REGADDR_WIDTH  destination register
- ex_jal_link_value  in  DATA_WIDTH  link value
- out_valid  out  1  MEM-side bundle valid
- out_ready  in  1  MEM consumes the bundle this cycle
- mem_reg_write, mem_mem_read, mem_mem_write, mem_branch, mem_is_jal  out  1 each  registered control bits
- mem_pc, mem_alu_result, mem_write_data, mem_rd, mem_jal_link_value  out  matching widths  registered data
- occupancy  out  2  entries held (0..2)
- stall_cycles  out  STALL_CNT_WIDTH  saturating stall count

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !skid_valid, driven directly from a register.
- Main register drives all mem_* outputs; out_valid = main_valid.
- Reset, asynchronous:
  - main_valid = skid_valid = 0; in_ready = 1; occupancy = 0; stall_cycles = 0.
  - All mem_* outputs are 0.
- Latency: 1 cycle from in_fire to out_valid when main is empty or draining.
- Next-state rules (on clk, flush inactive):
  - Main empty and in_fire: main loads the input; out_valid = 1.
  - Main full, out_fire, skid empty, in_fire: main loads the input (streaming, full throughput).
  - Main full, out_fire, skid empty, no in_fire: main_valid -> 0 and all mem_* control bits -> 0. Data fields may hold their last values.
  - Main full, !out_ready, in_fire: skid captures the input; in_ready = 0 next cycle.
  - Main full, out_fire, skid full: main loads from skid; skid_valid -> 0; in_ready = 1 next cycle.
  - Main full, !out_ready, no in_fire: everything holds, all outputs stable.
- Bundle integrity:
  - Bundles are never dropped, duplicated or reordered.
  - mem_* outputs change only on out_fire, on a main load from empty, on flush, or on reset.
- ZERO_REG_SQUASH=1: the captured reg_write = ex_reg_write & (ex_rd != 0). This applies at capture into both main and skid; all other fields are unaffected.
- mem_write_data is ex_reg_data2 of the same bundle.
- Flush (synchronous, highest priority):
  - Next cycle: main_valid = skid_valid = 0, all mem_* control bits = 0, in_ready = 1, occupancy = 0.
  - A simultaneous in_fire bundle is discarded.
  - A simultaneous out_fire still completes in the flush cycle; the consumer has already sampled it.
- occupancy = main_valid + skid_valid; skid_valid implies main_valid.
- stall_cycles:
  - Increments each cycle out_valid & !out_ready is true.
  - Saturates at all-ones.
  - Cleared only by reset, not by flush.
- Reset mid-stall: both entries are lost immediately; out_valid drops asynchronously.

Test Plan:
- Reset then stream with out_ready=1: bundles pc=0x0010, 0x0014, 0x0018 accepted on consecutive cycles -> out_valid from the next cycle; mem_pc 0x0010, 0x0014, 0x0018 on consecutive cycles; in_ready stays 1; occupancy ≤ 1.
- Backpressure: out_ready=0 while pc=0x0020 and then 0x0024 are sent -> occupancy 2, in_ready=0, mem_pc holds 0x0020, stall_cycles counts. Raise out_ready -> 0x0020 then 0x0024 delivered in order; in_ready returns to 1.
- Flush with both entries full plus a simultaneous in_valid (pc=0x0030) -> next cycle out_valid=0, all mem_* controls 0, occupancy 0, in_ready=1; 0x0030 never appears at the output.
- ZERO_REG_SQUASH: ex_reg_write=1 with ex_rd=0 -> mem_reg_write=0. ex_reg_write=1 with ex_rd=5 -> mem_reg_write=1, mem_rd=5. Both checked via main and via the skid path.
- Stall saturation with STALL_CNT_WIDTH=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cycles reaches 15 and stays 15; a flush does not clear it; reset does.
- Async reset asserted mid-backpressure with occupancy 2 and store bundle (ex_mem_write=1, data 0xBEEF) -> out_valid and mem_mem_write drop to 0 without a clock edge; after release, in_ready=1 and occupancy=0.

Source files
------------

// File: rtl/ex_mem_skid_if.sv
// EX -> MEM handshake and bundle signals for the elastic EX/MEM stage.
// slave: the pipeline stage itself; master: the surrounding EX/MEM logic.
interface ex_mem_skid_if #(
    parameter int PC_WIDTH      = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int REGADDR_WIDTH = 4
) ();
    // EX side
    logic                     in_valid;
    logic                     in_ready;
    logic                     ex_reg_write;
    logic                     ex_mem_read;
    logic                     ex_mem_write;
    logic                     ex_branch;
    logic                     ex_is_jal;
    logic [PC_WIDTH-1:0]      ex_pc;
    logic [DATA_WIDTH-1:0]    ex_alu_result;
    logic [DATA_WIDTH-1:0]    ex_reg_data2;
    logic [REGADDR_WIDTH-1:0] ex_rd;
    logic [DATA_WIDTH-1:0]    ex_jal_link_value;

    // MEM side
    logic                     out_valid;
    logic                     out_ready;
    logic                     mem_reg_write;
    logic                     mem_mem_read;
    logic                     mem_mem_write;
    logic                     mem_branch;
    logic                     mem_is_jal;
    logic [PC_WIDTH-1:0]      mem_pc;
    logic [DATA_WIDTH-1:0]    mem_alu_result;
    logic [DATA_WIDTH-1:0]    mem_write_data;
    logic [REGADDR_WIDTH-1:0] mem_rd;
    logic [DATA_WIDTH-1:0]    mem_jal_link_value;

    modport slave (
        input  in_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
               ex_is_jal, ex_pc, ex_alu_result, ex_reg_data2, ex_rd,
               ex_jal_link_value, out_ready,
        output in_ready, out_valid, mem_reg_write, mem_mem_read, mem_mem_write,
               mem_branch, mem_is_jal, mem_pc, mem_alu_result, mem_write_data,
               mem_rd, mem_jal_link_value
    );

    modport master (
        output in_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
               ex_is_jal, ex_pc, ex_alu_result, ex_reg_data2, ex_rd,
               ex_jal_link_value, out_ready,
        input  in_ready, out_valid, mem_reg_write, mem_mem_read, mem_mem_write,
               mem_branch, mem_is_jal, mem_pc, mem_alu_result, mem_write_data,
               mem_rd, mem_jal_link_value
    );
endinterface

// File: rtl/ex_mem_skid.sv
// Elastic EX/MEM pipeline register: main entry drives MEM, skid entry
// absorbs one extra bundle so in_ready comes straight from a flop.
module ex_mem_skid #(
    parameter int PC_WIDTH        = 16,
    parameter int DATA_WIDTH      = 16,
    parameter int REGADDR_WIDTH   = 4,
    parameter int ZERO_REG_SQUASH = 1,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    ex_mem_skid_if.slave               bus,
    output logic [1:0]                 occupancy,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

    typedef struct packed {
        logic                     reg_write;
        logic                     mem_read;
        logic                     mem_write;
        logic                     branch;
        logic                     is_jal;
        logic [PC_WIDTH-1:0]      pc;
        logic [DATA_WIDTH-1:0]    alu_result;
        logic [DATA_WIDTH-1:0]    write_data;
        logic [REGADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    jal_link_value;
    } bundle_t;

    // Encoding equals the number of held entries.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } state_t;

    state_t                     state_q;
    bundle_t                    main_q;
    bundle_t                    skid_q;
    bundle_t                    in_bundle;
    logic                       main_valid_q;
    logic                       skid_valid_q;
    logic                       in_ready_q;
    logic                       in_fire;
    logic [STALL_CNT_WIDTH-1:0] stall_q;

    // Invalidated entries must not present live control bits to MEM.
    function automatic bundle_t clear_ctrl(input bundle_t b);
        bundle_t r;
        r           = b;
        r.reg_write = 1'b0;
        r.mem_read  = 1'b0;
        r.mem_write = 1'b0;
        r.branch    = 1'b0;
        r.is_jal    = 1'b0;
        return r;
    endfunction

    assign in_fire = bus.in_valid & in_ready_q;

    // Assemble the incoming bundle, squashing writes to x0 when enabled.
    always_comb begin
        in_bundle                = '0;
        in_bundle.reg_write      = bus.ex_reg_write &
                                   ((ZERO_REG_SQUASH == 0) || (bus.ex_rd != '0));
        in_bundle.mem_read       = bus.ex_mem_read;
        in_bundle.mem_write      = bus.ex_mem_write;
        in_bundle.branch         = bus.ex_branch;
        in_bundle.is_jal         = bus.ex_is_jal;
        in_bundle.pc             = bus.ex_pc;
        in_bundle.alu_result     = bus.ex_alu_result;
        in_bundle.write_data     = bus.ex_reg_data2;
        in_bundle.rd             = bus.ex_rd;
        in_bundle.jal_link_value = bus.ex_jal_link_value;
    end

    // Occupancy FSM: moves bundles between input, skid and main entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= OCC_EMPTY;
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (flush) begin
            state_q      <= OCC_EMPTY;
            main_q       <= clear_ctrl(main_q);
            skid_q       <= clear_ctrl(skid_q);
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        main_q       <= in_bundle;
                        main_valid_q <= 1'b1;
                        state_q      <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (bus.out_ready) begin
                        if (in_fire) begin
                            main_q <= in_bundle;
                        end else begin
                            main_q       <= clear_ctrl(main_q);
                            main_valid_q <= 1'b0;
                            state_q      <= OCC_EMPTY;
                        end
                    end else if (in_fire) begin
                        skid_q       <= in_bundle;
                        skid_valid_q <= 1'b1;
                        in_ready_q   <= 1'b0;
                        state_q      <= OCC_TWO;
                    end
                end
                OCC_TWO: begin
                    // in_ready is low here, so only the drain case matters.
                    if (bus.out_ready) begin
                        main_q       <= skid_q;
                        skid_q       <= clear_ctrl(skid_q);
                        skid_valid_q <= 1'b0;
                        in_ready_q   <= 1'b1;
                        state_q      <= OCC_ONE;
                    end
                end
                default: begin
                    state_q      <= OCC_EMPTY;
                    main_valid_q <= 1'b0;
                    skid_valid_q <= 1'b0;
                    in_ready_q   <= 1'b1;
                end
            endcase
        end
    end

    // Saturating count of cycles MEM holds off a valid bundle; flush keeps it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (main_valid_q && !bus.out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.in_ready           = in_ready_q;
    assign bus.out_valid          = main_valid_q;
    assign bus.mem_reg_write      = main_q.reg_write;
    assign bus.mem_mem_read       = main_q.mem_read;
    assign bus.mem_mem_write      = main_q.mem_write;
    assign bus.mem_branch         = main_q.branch;
    assign bus.mem_is_jal         = main_q.is_jal;
    assign bus.mem_pc             = main_q.pc;
    assign bus.mem_alu_result     = main_q.alu_result;
    assign bus.mem_write_data     = main_q.write_data;
    assign bus.mem_rd             = main_q.rd;
    assign bus.mem_jal_link_value = main_q.jal_link_value;
    assign occupancy              = state_q;
    assign stall_cycles           = stall_q;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed bench for ex_mem_skid with a bundle scoreboard and a small
// occupancy/stall reference model.
module tb_ex_mem_skid;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        is_jal;
        logic [15:0] pc;
        logic [15:0] alu_result;
        logic [15:0] write_data;
        logic [3:0]  rd;
        logic [15:0] jal_link_value;
    } bundle_t;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [1:0] occupancy;
    logic [3:0] stall_cycles;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_occ  = 0;
    int m_stall = 0;
    bundle_t sb[$];

    logic [15:0] cur_pc;
    logic        cur_rw;
    logic [3:0]  cur_rd;
    logic        cur_mw;
    logic [15:0] cur_d2;

    ex_mem_skid_if #(.PC_WIDTH(16), .DATA_WIDTH(16), .REGADDR_WIDTH(4)) bi ();

    ex_mem_skid #(
        .PC_WIDTH(16),
        .DATA_WIDTH(16),
        .REGADDR_WIDTH(4),
        .ZERO_REG_SQUASH(1),
        .STALL_CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .bus(bi),
        .occupancy(occupancy),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bundle_t mk(input logic [15:0] pc, input logic rw, input logic [3:0] rd,
                                   input logic mw, input logic [15:0] d2);
        bundle_t b;
        b.reg_write      = rw & (rd != 4'd0);
        b.mem_read       = pc[2];
        b.mem_write      = mw;
        b.branch         = pc[3];
        b.is_jal         = pc[4];
        b.pc             = pc;
        b.alu_result     = pc ^ 16'h5A5A;
        b.write_data     = d2;
        b.rd             = rd;
        b.jal_link_value = pc + 16'd4;
        return b;
    endfunction

    task automatic set_in(input logic v, input logic [15:0] pc, input logic rw,
                          input logic [3:0] rd, input logic mw, input logic [15:0] d2);
        cur_pc = pc; cur_rw = rw; cur_rd = rd; cur_mw = mw; cur_d2 = d2;
        bi.in_valid          = v;
        bi.ex_reg_write      = rw;
        bi.ex_mem_read       = pc[2];
        bi.ex_mem_write      = mw;
        bi.ex_branch         = pc[3];
        bi.ex_is_jal         = pc[4];
        bi.ex_pc             = pc;
        bi.ex_alu_result     = pc ^ 16'h5A5A;
        bi.ex_reg_data2      = d2;
        bi.ex_rd             = rd;
        bi.ex_jal_link_value = pc + 16'd4;
    endtask

    function automatic bundle_t dut_bundle();
        bundle_t b;
        b = {bi.mem_reg_write, bi.mem_mem_read, bi.mem_mem_write, bi.mem_branch,
             bi.mem_is_jal, bi.mem_pc, bi.mem_alu_result, bi.mem_write_data,
             bi.mem_rd, bi.mem_jal_link_value};
        return b;
    endfunction

    // Check current state, update the model for the coming edge, advance one cycle.
    task automatic tick();
        logic    m_in_ready;
        logic    m_out_valid;
        logic    inf;
        logic    outf;
        bundle_t e;
        m_in_ready  = (m_occ != 2);
        m_out_valid = (m_occ != 0);
        chk("in_ready", 128'(bi.in_ready), 128'(m_in_ready));
        chk("out_valid", 128'(bi.out_valid), 128'(m_out_valid));
        chk("occupancy", 128'(occupancy), 128'(m_occ));
        chk("stall_cycles", 128'(stall_cycles), 128'(m_stall));
        if (!m_out_valid)
            chk("idle_ctrl", 128'({bi.mem_reg_write, bi.mem_mem_read, bi.mem_mem_write,
                                   bi.mem_branch, bi.mem_is_jal}), 128'(5'b0));
        inf  = bi.in_valid & m_in_ready;
        outf = m_out_valid & bi.out_ready;
        if (outf) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 128'(1), 128'(0));
            end else begin
                e = sb.pop_front();
                chk("bundle", 128'(dut_bundle()), 128'(e));
            end
        end
        if (m_out_valid && !bi.out_ready && m_stall != 15) m_stall++;
        if (flush) begin
            sb.delete();
            m_occ = 0;
        end else begin
            if (inf) sb.push_back(mk(cur_pc, cur_rw, cur_rd, cur_mw, cur_d2));
            m_occ = m_occ + int'(inf) - int'(outf);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bi.out_ready = 1'b0;
        set_in(1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 16'h0);
        #1;
        chk("rst_in_ready", 128'(bi.in_ready), 128'(1));
        chk("rst_out_valid", 128'(bi.out_valid), 128'(0));
        chk("rst_occupancy", 128'(occupancy), 128'(0));
        chk("rst_stall", 128'(stall_cycles), 128'(0));
        chk("rst_bundle", 128'(dut_bundle()), 128'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Streaming at full throughput, x0 squash through main
        bi.out_ready = 1'b1;
        set_in(1'b1, 16'h0010, 1'b1, 4'd1, 1'b0, 16'h1111); tick();
        set_in(1'b1, 16'h0014, 1'b1, 4'd2, 1'b0, 16'h2222); tick();
        set_in(1'b1, 16'h0018, 1'b0, 4'd3, 1'b1, 16'h3333); tick();
        set_in(1'b1, 16'h0040, 1'b1, 4'd0, 1'b0, 16'h4444); tick();
        set_in(1'b1, 16'h0044, 1'b1, 4'd5, 1'b0, 16'h5555); tick();
        set_in(1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 16'h0000); tick();
        tick();

        // Backpressure: 0x0020 in main, 0x0024 (x0 write) in skid, 0x0028 refused
        bi.out_ready = 1'b0;
        set_in(1'b1, 16'h0020, 1'b1, 4'd0, 1'b0, 16'hA020); tick();
        set_in(1'b1, 16'h0024, 1'b1, 4'd0, 1'b0, 16'hA024); tick();
        set_in(1'b1, 16'h0028, 1'b1, 4'd3, 1'b0, 16'hA028); tick();
        tick();
        chk("hold_pc", 128'(bi.mem_pc), 128'(16'h0020));
        set_in(1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 16'h0000);
        bi.out_ready = 1'b1;
        tick(); tick(); tick();

        // Skid path with rd=5, then long stall to saturate the counter
        bi.out_ready = 1'b0;
        set_in(1'b1, 16'h0050, 1'b1, 4'd5, 1'b0, 16'hB050); tick();
        set_in(1'b1, 16'h0054, 1'b1, 4'd5, 1'b1, 16'hB054); tick();
        set_in(1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 16'h0000);
        for (int i = 0; i < 20; i++) tick();
        chk("stall_sat", 128'(stall_cycles), 128'(4'hF));
        bi.out_ready = 1'b1;
        tick(); tick(); tick();

        // Flush with both entries full and a pending input
        bi.out_ready = 1'b0;
        set_in(1'b1, 16'h0060, 1'b1, 4'd6, 1'b0, 16'hC060); tick();
        set_in(1'b1, 16'h0064, 1'b1, 4'd7, 1'b0, 16'hC064); tick();
        set_in(1'b1, 16'h0030, 1'b1, 4'd2, 1'b0, 16'hC030);
        flush = 1'b1; tick(); flush = 1'b0;
        set_in(1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 16'h0000);
        bi.out_ready = 1'b1;
        tick(); tick();
        chk("stall_after_flush", 128'(stall_cycles), 128'(4'hF));

        // Flush coinciding with out_fire and in_fire at occupancy 1
        set_in(1'b1, 16'h0068, 1'b1, 4'd8, 1'b0, 16'hD068); tick();
        set_in(1'b1, 16'h0034, 1'b1, 4'd9, 1'b0, 16'hD034);
        flush = 1'b1; tick(); flush = 1'b0;
        set_in(1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 16'h0000);
        tick(); tick();

        // Asynchronous reset in the middle of a two-entry store stall
        bi.out_ready = 1'b0;
        set_in(1'b1, 16'h0070, 1'b0, 4'd0, 1'b1, 16'hBEEF); tick();
        set_in(1'b1, 16'h0074, 1'b0, 4'd0, 1'b1, 16'hBEEF); tick();
        set_in(1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 16'h0000);
        chk("pre_reset_occ", 128'(occupancy), 128'(2));
        chk("pre_reset_mw", 128'(bi.mem_mem_write), 128'(1));
        #2 reset = 1'b1;
        #1;
        chk("async_out_valid", 128'(bi.out_valid), 128'(0));
        chk("async_mem_write", 128'(bi.mem_mem_write), 128'(0));
        chk("async_occupancy", 128'(occupancy), 128'(0));
        chk("async_stall", 128'(stall_cycles), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        m_occ = 0;
        m_stall = 0;
        sb.delete();
        chk("post_reset_in_ready", 128'(bi.in_ready), 128'(1));
        bi.out_ready = 1'b1;
        tick(); tick();
        chk("sb_drained", 128'(sb.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
